// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a shared combinational ROM: instruction fetch has
// priority, data reads are protected from starvation, and responses are registered.
module rom_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [30:0] if_addr,
    input  logic        if_flush,
    output logic        if_ack,
    output logic [31:0] if_data,
    output logic        if_ovf,
    input  logic        dr_req,
    input  logic [30:0] dr_addr,
    output logic        dr_ack,
    output logic [31:0] dr_data,
    output logic        dr_ovf,
    output logic [30:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        rom_ovf
);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_IF,
        GNT_DR
    } grant_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    grant_e     grant;
    logic [3:0] starve_cnt;
    logic       dr_starved;

    assign dr_starved = (starve_cnt == STARVE_LIM);

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        grant    = GNT_NONE;
        rom_addr = if_addr;
        // Requests seen while reset is low are ignored outright.
        if (reset) begin
            if (if_req && !if_flush && !(dr_req && dr_starved)) begin
                grant = GNT_IF;
            end else if (dr_req) begin
                grant = GNT_DR;
            end
        end
        if (grant == GNT_DR) begin
            rom_addr = dr_addr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if_ack     <= 1'b0;
            if_data    <= 32'h0;
            if_ovf     <= 1'b0;
            dr_ack     <= 1'b0;
            dr_data    <= 32'h0;
            dr_ovf     <= 1'b0;
            starve_cnt <= 4'd0;
        end else begin
            if_ack <= (grant == GNT_IF);
            dr_ack <= (grant == GNT_DR);

            if (grant == GNT_IF) begin
                if_data <= rom_data;
                if_ovf  <= rom_ovf;
            end
            if (grant == GNT_DR) begin
                dr_data <= rom_data;
                dr_ovf  <= rom_ovf;
            end

            // A flush always hands the slot to a pending data read, so a flushed
            // cycle can never register as a loss here.
            if (dr_req && grant != GNT_DR) begin
                if (!dr_starved) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                starve_cnt <= 4'd0;
            end
        end
    end

endmodule
